trigger_surround_cache: RTL and testbench

//  Capture engine between the 8-bit ADC front end and the serial readout link. After

---
 rtl/tsc_pkg.sv | 19 +
 rtl/tsc_ring_buffer.sv | 32 +++
 rtl/trigger_surround_cache.sv | 175 +++++++++++++++++
 tb/tb_trigger_surround_cache.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tsc_pkg.sv
// Shared types and default parameters for the trigger surround cache.
// State codes are visible on the debug port, so their values are fixed.
package tsc_pkg;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 32;
  localparam int PRE_TRIG  = 16;
  localparam int TS_W      = 32;
  localparam logic [7:0] TRIG_LVL = 8'hD5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_RUN  = 4'd1,
    ST_POST = 4'd2,
    ST_DONE = 4'd3,
    ST_SEND = 4'd4
  } state_e;

endpackage

// File: rtl/tsc_ring_buffer.sv
// Sample ring storage: one write port, one asynchronous read port,
// synchronous whole-array clear.
module tsc_ring_buffer #(
  parameter int DATA_W = tsc_pkg::DATA_W,
  parameter int DEPTH  = tsc_pkg::BUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/trigger_surround_cache.sv
// Capture engine: rings ADC samples, freezes a window around the first
// sample at or above the trigger level, then shifts it out MSB first.
module trigger_surround_cache #(
  parameter int DATA_W    = tsc_pkg::DATA_W,
  parameter int BUF_DEPTH = tsc_pkg::BUF_DEPTH,
  parameter int PRE_TRIG  = tsc_pkg::PRE_TRIG,
  parameter int TS_W      = tsc_pkg::TS_W,
  parameter logic [DATA_W-1:0] TRIG_LVL = tsc_pkg::TRIG_LVL
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              req,
  input  logic              sbf,
  output logic              trd,
  output logic              cd,
  output logic              rdy,
  output logic              sd,
  output logic [TS_W-1:0]   trigtm,
  output logic [3:0]        current_state
);

  import tsc_pkg::*;

  localparam int AW    = $clog2(BUF_DEPTH);
  localparam int NBITS = BUF_DEPTH * DATA_W;
  localparam int BW    = $clog2(NBITS);
  localparam int SW    = $clog2(DATA_W);
  localparam int POST_N = BUF_DEPTH - PRE_TRIG - 1;

  localparam logic [AW:0]   PRE_FULL  = (AW+1)'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
  localparam logic [SW-1:0] BYTE_LAST = SW'(DATA_W - 1);

  state_e            state_q;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   trigtm_q;
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     tidx_q;
  logic [AW-1:0]     pcnt_q;
  logic [AW:0]       fill_q;
  logic [BW-1:0]     bcnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              trd_q;
  logic              cd_q;
  logic              rdy_q;

  logic              hit;
  logic              we;
  logic              clr;
  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     raddr;
  logic [AW:0]       gap;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rbyte;

  assign hit = adc_data >= TRIG_LVL;
  assign we  = req && (state_q == ST_RUN || state_q == ST_POST);
  assign clr = (state_q == ST_DONE) && start && !sbf;

  // Byte about to be loaded into the shifter, counted from window start.
  assign rd_idx = (state_q == ST_SEND)
                ? bcnt_q[BW-1:SW] + 1'b1
                : '0;
  assign raddr  = tidx_q - PRE_OFS + rd_idx;

  // Leading pre-trigger slots never written in this run read as zero.
  assign gap   = PRE_FULL - fill_q;
  assign rbyte = ({1'b0, rd_idx} < gap) ? '0 : rdata;

  tsc_ring_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (clr),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (adc_data),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ts_q     <= '0;
      trigtm_q <= '0;
      wptr_q   <= '0;
      tidx_q   <= '0;
      pcnt_q   <= '0;
      fill_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      trd_q    <= 1'b0;
      cd_q     <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      ts_q <= (state_q == ST_IDLE) ? '0 : ts_q + 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          wptr_q <= '0;
          fill_q <= '0;
          if (start) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (req) begin
            wptr_q <= wptr_q + 1'b1;
            if (hit) begin
              trd_q    <= 1'b1;
              trigtm_q <= ts_q;
              tidx_q   <= wptr_q;
              pcnt_q   <= '0;
              state_q  <= ST_POST;
            end else if (fill_q != PRE_FULL) begin
              fill_q <= fill_q + 1'b1;
            end
          end
        end
        ST_POST: begin
          if (req) begin
            wptr_q <= wptr_q + 1'b1;
            pcnt_q <= pcnt_q + 1'b1;
            if (pcnt_q == POST_LAST) begin
              cd_q    <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (sbf) begin
            rdy_q   <= 1'b1;
            bcnt_q  <= '0;
            shift_q <= rbyte;
            state_q <= ST_SEND;
          end else if (start) begin
            trd_q   <= 1'b0;
            cd_q    <= 1'b0;
            wptr_q  <= '0;
            fill_q  <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_SEND: begin
          if (bcnt_q == BIT_LAST) begin
            rdy_q   <= 1'b0;
            trd_q   <= 1'b0;
            cd_q    <= 1'b0;
            shift_q <= '0;
            state_q <= ST_IDLE;
          end else begin
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q[SW-1:0] == BYTE_LAST)
              shift_q <= rbyte;
            else
              shift_q <= {shift_q[DATA_W-2:0], 1'b0};
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign trd           = trd_q;
  assign cd            = cd_q;
  assign rdy           = rdy_q;
  assign sd            = rdy_q & shift_q[DATA_W-1];
  assign trigtm        = trigtm_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_trigger_surround_cache.sv
// Bench for trigger_surround_cache: window-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_trigger_surround_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  adc;
  logic        req;
  logic        sbf;
  logic        trd;
  logic        cd;
  logic        rdy;
  logic        sd;
  logic [31:0] trigtm;
  logic [3:0]  current_state;

  int checks = 0;
  int errors = 0;

  trigger_surround_cache dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .adc_data      (adc),
    .req           (req),
    .sbf           (sbf),
    .trd           (trd),
    .cd            (cd),
    .rdy           (rdy),
    .sd            (sd),
    .trigtm        (trigtm),
    .current_state (current_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: phase, captured history and the frozen window bytes.
  int          m_st;
  logic        m_trd, m_cd, m_rdy;
  logic [31:0] m_trigtm;
  int          m_cyc = 0;
  int          m_t0 = 0;
  int          m_bit;
  int          m_npost;
  logic [7:0]  m_hist[$];
  logic [7:0]  m_win[32];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_st = 0; m_trd = 0; m_cd = 0; m_rdy = 0;
      m_trigtm = 0; m_bit = 0; m_npost = 0;
      m_hist.delete();
    end else begin
      m_cyc++;
      case (m_st)
        0: if (start) begin
          m_st = 1; m_t0 = m_cyc; m_hist.delete();
        end
        1: if (req) begin
          if (adc >= 8'hD5) begin
            m_trd = 1;
            m_trigtm = 32'(m_cyc - m_t0 - 1);
            for (int k = 0; k < 16; k++) begin
              int idx;
              idx = m_hist.size() - 16 + k;
              m_win[k] = (idx >= 0) ? m_hist[idx] : 8'h00;
            end
            m_win[16] = adc;
            m_npost = 0;
            m_st = 2;
          end else begin
            m_hist.push_back(adc);
            if (m_hist.size() > 16) void'(m_hist.pop_front());
          end
        end
        2: if (req) begin
          m_win[17 + m_npost] = adc;
          m_npost++;
          if (m_npost == 15) begin m_cd = 1; m_st = 3; end
        end
        3: if (sbf) begin
          m_st = 4; m_rdy = 1; m_bit = 0;
        end else if (start) begin
          m_st = 1; m_trd = 0; m_cd = 0; m_hist.delete();
        end
        4: if (m_bit == 255) begin
          m_st = 0; m_rdy = 0; m_trd = 0; m_cd = 0;
        end else m_bit++;
        default: m_st = 0;
      endcase
    end
  end

  always begin
    logic exp_sd;
    @(posedge clk);
    #1;
    exp_sd = m_rdy ? m_win[m_bit / 8][7 - (m_bit % 8)] : 1'b0;
    chk("model_state", 32'(current_state), 32'(m_st));
    chk("model_trd", 32'(trd), 32'(m_trd));
    chk("model_cd", 32'(cd), 32'(m_cd));
    chk("model_rdy", 32'(rdy), 32'(m_rdy));
    chk("model_sd", 32'(sd), 32'(exp_sd));
    chk("model_trigtm", trigtm, m_trigtm);
  end

  task automatic drive(input logic s, input logic r,
                       input logic [7:0] d, input logic b);
    @(negedge clk);
    start = s; req = r; adc = d; sbf = b;
  endtask

  logic [7:0] cap[32];
  int nbits;

  task automatic send_all();
    drive(0, 0, 8'h00, 1);
    nbits = 0;
    for (int k = 0; k < 32; k++) cap[k] = 8'h00;
    for (int i = 0; i < 300; i++) begin
      drive(0, 0, 8'h00, 0);
      if (i == 0) chk("send_state", 32'(current_state), 32'd4);
      if (rdy) begin
        if (nbits < 256) cap[nbits / 8] = {cap[nbits / 8][6:0], sd};
        nbits++;
      end else if (nbits > 0) break;
    end
    chk("send_len", 32'(nbits), 32'd256);
    chk("after_send_state", 32'(current_state), 32'd0);
    chk("after_send_trd", 32'(trd), 32'd0);
    chk("after_send_cd", 32'(cd), 32'd0);
  endtask

  task automatic posts(input logic [7:0] base);
    for (int k = 0; k < 15; k++) drive(0, 1, base + 8'(k), 0);
    drive(0, 0, 8'h00, 0);
    chk("done_state", 32'(current_state), 32'd3);
    chk("done_cd", 32'(cd), 32'd1);
  endtask

  initial begin
    logic [7:0] eb;
    reset = 1'b0; start = 0; req = 0; adc = 8'h00; sbf = 0;
    #3;
    chk("rst_state", 32'(current_state), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_trigtm", trigtm, 32'd0);
    #7 reset = 1'b1;
    repeat (3) drive(0, 0, 8'h00, 0);
    chk("idle_state", 32'(current_state), 32'd0);
    chk("idle_trd", 32'(trd), 32'd0);

    // Basic capture: 20 pre samples, trigger, 15 posts.
    drive(1, 0, 8'h00, 0);
    for (int k = 0; k < 20; k++) drive(0, 1, 8'h10, 0);
    drive(0, 1, 8'hE0, 0);
    drive(0, 1, 8'h20, 0);
    chk("t2_state", 32'(current_state), 32'd2);
    chk("t2_trd", 32'(trd), 32'd1);
    chk("t2_trigtm", trigtm, 32'd20);
    for (int k = 1; k < 15; k++) drive(0, 1, 8'h20 + 8'(k), 0);
    drive(0, 0, 8'h00, 0);
    chk("t2_done", 32'(current_state), 32'd3);
    chk("t2_cd", 32'(cd), 32'd1);
    send_all();
    for (int k = 0; k < 32; k++) begin
      eb = (k < 16) ? 8'h10 : (k == 16) ? 8'hE0 : 8'h20 + 8'(k - 17);
      chk($sformatf("t3_byte%0d", k), 32'(cap[k]), 32'(eb));
    end

    // Early trigger: only two pre samples exist.
    drive(1, 0, 8'h00, 0);
    drive(0, 1, 8'h30, 0);
    drive(0, 1, 8'h31, 0);
    drive(0, 1, 8'hF0, 0);
    posts(8'h40);
    chk("t4_trigtm", trigtm, 32'd2);
    send_all();
    for (int k = 0; k < 32; k++) begin
      eb = (k < 14) ? 8'h00 : (k == 14) ? 8'h30 : (k == 15) ? 8'h31 :
           (k == 16) ? 8'hF0 : 8'h40 + 8'(k - 17);
      chk($sformatf("t4_byte%0d", k), 32'(cap[k]), 32'(eb));
    end

    // Threshold edge, idle strobes, sample on the start cycle.
    drive(1, 1, 8'hE0, 0);
    drive(0, 1, 8'hD4, 0);
    repeat (3) drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'hD4, 0);
    drive(0, 1, 8'hD5, 0);
    chk("t5_pre_state", 32'(current_state), 32'd1);
    chk("t5_pre_trd", 32'(trd), 32'd0);
    drive(0, 1, 8'h50, 0);
    chk("t5_state", 32'(current_state), 32'd2);
    chk("t5_trigtm", trigtm, 32'd5);
    for (int k = 1; k < 15; k++) drive(0, 1, 8'h50 + 8'(k), 0);
    drive(0, 0, 8'h00, 0);
    chk("t5_done", 32'(current_state), 32'd3);

    // Restart from DONE, sbf while running is ignored.
    drive(1, 1, 8'hFF, 0);
    drive(0, 0, 8'h00, 1);
    chk("rs_state", 32'(current_state), 32'd1);
    chk("rs_trd", 32'(trd), 32'd0);
    chk("rs_cd", 32'(cd), 32'd0);
    drive(0, 0, 8'h00, 1);
    chk("rs_sbf_ign", 32'(current_state), 32'd1);
    drive(0, 1, 8'h61, 0);
    drive(0, 1, 8'hD9, 0);
    posts(8'h70);

    // Asynchronous reset in the middle of readout.
    drive(0, 0, 8'h00, 1);
    repeat (40) drive(0, 0, 8'h00, 0);
    chk("t6_rdy_before", 32'(rdy), 32'd1);
    chk("t6_state_before", 32'(current_state), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("t6_rdy", 32'(rdy), 32'd0);
    chk("t6_sd", 32'(sd), 32'd0);
    chk("t6_state", 32'(current_state), 32'd0);
    chk("t6_trd", 32'(trd), 32'd0);
    chk("t6_trigtm", trigtm, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) drive(0, 0, 8'h00, 0);
    chk("t6_idle", 32'(current_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
